// File: rtl/rs_station.sv
// rtl/rs_station.sv - reservation station with CDB snoop, age-matrix select and registered issue port
// Holds DEPTH renamed instructions and issues the oldest ready one per cycle.
module rs_station #(
    parameter int DEPTH     = 16,
    parameter int TAG_W     = 4,
    parameter int DATA_W    = 32,
    parameter int OP_W      = 6,
    parameter int CDB_PORTS = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        rdy_i,
    input  logic                        flush_i,
    input  logic                        disp_valid_i,
    output logic                        disp_ready_o,
    input  logic [OP_W-1:0]             disp_op_i,
    input  logic                        disp_qj_valid_i,
    input  logic                        disp_qk_valid_i,
    input  logic [TAG_W-1:0]            disp_qj_i,
    input  logic [TAG_W-1:0]            disp_qk_i,
    input  logic [DATA_W-1:0]           disp_vj_i,
    input  logic [DATA_W-1:0]           disp_vk_i,
    input  logic [DATA_W-1:0]           disp_imm_i,
    input  logic [DATA_W-1:0]           disp_pc_i,
    input  logic [TAG_W-1:0]            disp_rob_i,
    input  logic [CDB_PORTS-1:0]        cdb_valid_i,
    input  logic [CDB_PORTS*TAG_W-1:0]  cdb_tag_i,
    input  logic [CDB_PORTS*DATA_W-1:0] cdb_data_i,
    output logic                        issue_valid_o,
    input  logic                        issue_ready_i,
    output logic [OP_W-1:0]             issue_op_o,
    output logic [DATA_W-1:0]           issue_vj_o,
    output logic [DATA_W-1:0]           issue_vk_o,
    output logic [DATA_W-1:0]           issue_imm_o,
    output logic [DATA_W-1:0]           issue_pc_o,
    output logic [TAG_W-1:0]            issue_rob_o,
    output logic [$clog2(DEPTH):0]      occupancy_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic              qj_valid;
        logic [TAG_W-1:0]  qj;
        logic [DATA_W-1:0] vj;
        logic              qk_valid;
        logic [TAG_W-1:0]  qk;
        logic [DATA_W-1:0] vk;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [TAG_W-1:0]  rob;
    } entry_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [TAG_W-1:0]  rob;
    } issue_t;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];
    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    entry_t           new_ent;
    issue_t           iss_q, iss_d;
    logic             iss_valid_q, iss_valid_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    logic [DEPTH-1:0] ready_vec, cand;
    logic [IDX_W-1:0] sel_idx, free_idx;
    logic             any_cand, alloc, load;

    function automatic logic cdb_hit(input logic [TAG_W-1:0] tag);
        cdb_hit = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++)
            if (cdb_valid_i[p] && cdb_tag_i[p*TAG_W +: TAG_W] == tag) cdb_hit = 1'b1;
    endfunction

    // Scanned high-to-low so the lowest matching port has the final say.
    function automatic logic [DATA_W-1:0] cdb_value(input logic [TAG_W-1:0] tag);
        cdb_value = '0;
        for (int p = CDB_PORTS - 1; p >= 0; p--)
            if (cdb_valid_i[p] && cdb_tag_i[p*TAG_W +: TAG_W] == tag)
                cdb_value = cdb_data_i[p*DATA_W +: DATA_W];
    endfunction

    assign disp_ready_o = rdy_i && (occ_q != FULL_OCC);
    assign alloc        = disp_valid_i && disp_ready_o;
    assign any_cand     = |cand;
    assign load         = (!iss_valid_q || issue_ready_i) && any_cand;

    // A ready entry is a candidate only if no other ready entry is older than it.
    always_comb begin
        ready_vec = '0;
        cand      = '0;
        for (int i = 0; i < DEPTH; i++)
            ready_vec[i] = busy_q[i] && !ent_q[i].qj_valid && !ent_q[i].qk_valid;
        for (int i = 0; i < DEPTH; i++) begin
            cand[i] = ready_vec[i];
            for (int j = 0; j < DEPTH; j++)
                if (ready_vec[j] && older_q[j][i]) cand[i] = 1'b0;
        end
    end

    always_comb begin
        sel_idx  = '0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cand[i])    sel_idx  = IDX_W'(i);
            if (!busy_q[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        new_ent          = '0;
        new_ent.op       = disp_op_i;
        new_ent.imm      = disp_imm_i;
        new_ent.pc       = disp_pc_i;
        new_ent.rob      = disp_rob_i;
        new_ent.qj       = disp_qj_i;
        new_ent.qk       = disp_qk_i;
        new_ent.qj_valid = disp_qj_valid_i && !cdb_hit(disp_qj_i);
        new_ent.qk_valid = disp_qk_valid_i && !cdb_hit(disp_qk_i);
        new_ent.vj       = (disp_qj_valid_i && cdb_hit(disp_qj_i)) ? cdb_value(disp_qj_i) : disp_vj_i;
        new_ent.vk       = (disp_qk_valid_i && cdb_hit(disp_qk_i)) ? cdb_value(disp_qk_i) : disp_vk_i;
    end

    always_comb begin
        busy_d  = busy_q;
        older_d = older_q;
        ent_d   = ent_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && ent_q[i].qj_valid && cdb_hit(ent_q[i].qj)) begin
                ent_d[i].qj_valid = 1'b0;
                ent_d[i].vj       = cdb_value(ent_q[i].qj);
            end
            if (busy_q[i] && ent_q[i].qk_valid && cdb_hit(ent_q[i].qk)) begin
                ent_d[i].qk_valid = 1'b0;
                ent_d[i].vk       = cdb_value(ent_q[i].qk);
            end
        end
        if (load) busy_d[sel_idx] = 1'b0;
        if (alloc) begin
            busy_d[free_idx]  = 1'b1;
            ent_d[free_idx]   = new_ent;
            older_d[free_idx] = '0;
            for (int j = 0; j < DEPTH; j++) older_d[j][free_idx] = busy_q[j];
        end
    end

    always_comb begin
        iss_valid_d = load || (iss_valid_q && !issue_ready_i);
        iss_d       = iss_q;
        if (load)
            iss_d = '{op: ent_q[sel_idx].op, vj: ent_q[sel_idx].vj, vk: ent_q[sel_idx].vk,
                      imm: ent_q[sel_idx].imm, pc: ent_q[sel_idx].pc, rob: ent_q[sel_idx].rob};
        occ_d = occ_q + {{IDX_W{1'b0}}, alloc} - {{IDX_W{1'b0}}, load};
    end

    // Flush wins over the rdy freeze so a mispredict is never held off.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q      <= '0;
            older_q     <= '{default: '0};
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
            occ_q       <= '0;
        end else if (flush_i) begin
            busy_q      <= '0;
            iss_valid_q <= 1'b0;
            occ_q       <= '0;
        end else if (rdy_i) begin
            busy_q      <= busy_d;
            older_q     <= older_d;
            iss_valid_q <= iss_valid_d;
            iss_q       <= iss_d;
            occ_q       <= occ_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rdy_i && !flush_i) ent_q <= ent_d;
    end

    assign issue_valid_o = iss_valid_q;
    assign issue_op_o    = iss_q.op;
    assign issue_vj_o    = iss_q.vj;
    assign issue_vk_o    = iss_q.vk;
    assign issue_imm_o   = iss_q.imm;
    assign issue_pc_o    = iss_q.pc;
    assign issue_rob_o   = iss_q.rob;
    assign occupancy_o   = occ_q;
endmodule

// File: tb/tb_rs_station.sv
// tb/tb_rs_station.sv - directed self-checking bench for rs_station
module tb_rs_station;
    localparam int DEPTH = 16, TAG_W = 4, DATA_W = 32, OP_W = 6, CDB_PORTS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rdy, flush, disp_valid, disp_ready, disp_qj_valid, disp_qk_valid;
    logic [OP_W-1:0] disp_op, issue_op;
    logic [TAG_W-1:0] disp_qj, disp_qk, disp_rob, issue_rob;
    logic [DATA_W-1:0] disp_vj, disp_vk, disp_imm, disp_pc;
    logic [CDB_PORTS-1:0] cdb_valid;
    logic [CDB_PORTS*TAG_W-1:0] cdb_tag;
    logic [CDB_PORTS*DATA_W-1:0] cdb_data;
    logic issue_valid, issue_ready;
    logic [DATA_W-1:0] issue_vj, issue_vk, issue_imm, issue_pc;
    logic [$clog2(DEPTH):0] occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    rs_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W), .CDB_PORTS(CDB_PORTS)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rdy_i(rdy), .flush_i(flush),
        .disp_valid_i(disp_valid), .disp_ready_o(disp_ready), .disp_op_i(disp_op),
        .disp_qj_valid_i(disp_qj_valid), .disp_qk_valid_i(disp_qk_valid),
        .disp_qj_i(disp_qj), .disp_qk_i(disp_qk), .disp_vj_i(disp_vj), .disp_vk_i(disp_vk),
        .disp_imm_i(disp_imm), .disp_pc_i(disp_pc), .disp_rob_i(disp_rob),
        .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
        .issue_valid_o(issue_valid), .issue_ready_i(issue_ready),
        .issue_op_o(issue_op), .issue_vj_o(issue_vj), .issue_vk_o(issue_vk),
        .issue_imm_o(issue_imm), .issue_pc_o(issue_pc), .issue_rob_o(issue_rob),
        .occupancy_o(occupancy)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        disp_valid = 0; disp_op = '0; disp_qj_valid = 0; disp_qk_valid = 0;
        disp_qj = '0; disp_qk = '0; disp_vj = '0; disp_vk = '0;
        disp_imm = '0; disp_pc = '0; disp_rob = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0; flush = 0;
    endtask

    task automatic disp(input logic [TAG_W-1:0] rob, input logic qjv, input logic [TAG_W-1:0] qj,
                        input logic [DATA_W-1:0] vj, input logic qkv, input logic [TAG_W-1:0] qk,
                        input logic [DATA_W-1:0] vk);
        disp_valid = 1; disp_rob = rob; disp_qj_valid = qjv; disp_qj = qj; disp_vj = vj;
        disp_qk_valid = qkv; disp_qk = qk; disp_vk = vk;
    endtask

    task automatic cdb(input int port, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        cdb_valid[port] = 1'b1;
        cdb_tag[port*TAG_W +: TAG_W] = tag;
        cdb_data[port*DATA_W +: DATA_W] = data;
    endtask

    // Return to empty through a flush so each scenario starts clean.
    task automatic drain();
        idle(); flush = 1; step(); flush = 0;
    endtask

    task automatic test_reset();
        idle(); rdy = 1; issue_ready = 0; rst_n = 0;
        #12;
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue_valid got %b want 0", issue_valid); end
        n_checks++; if (occupancy !== '0) begin n_fail++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        n_checks++; if (issue_vj !== '0 || issue_rob !== '0) begin n_fail++; $display("FAIL reset_issue_data got vj=%h rob=%0d want 0", issue_vj, issue_rob); end
        @(negedge clk); rst_n = 1; #1;
        n_checks++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_disp_ready got %b want 1", disp_ready); end
        @(negedge clk);
    endtask

    task automatic test_ready_dispatch();
        issue_ready = 1;
        disp(4'd3, 0, 0, 32'd5, 0, 0, 32'd7);
        disp_op = 6'h15; disp_imm = 32'h100; disp_pc = 32'h4000;
        step(); idle();
        n_checks++; if (issue_valid !== 1'b0 || occupancy !== 1) begin n_fail++; $display("FAIL ready_edge1 got valid=%b occ=%0d want 0/1", issue_valid, occupancy); end
        step();
        n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL ready_issue_valid got %b want 1", issue_valid); end
        n_checks++; if (issue_vj !== 32'd5 || issue_vk !== 32'd7) begin n_fail++; $display("FAIL ready_operands got %0d/%0d want 5/7", issue_vj, issue_vk); end
        n_checks++; if (issue_rob !== 4'd3 || issue_op !== 6'h15) begin n_fail++; $display("FAIL ready_rob_op got %0d/%h want 3/15", issue_rob, issue_op); end
        n_checks++; if (issue_imm !== 32'h100 || issue_pc !== 32'h4000) begin n_fail++; $display("FAIL ready_imm_pc got %h/%h want 100/4000", issue_imm, issue_pc); end
        n_checks++; if (occupancy !== 0) begin n_fail++; $display("FAIL ready_occupancy got %0d want 0", occupancy); end
        step();
        n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL ready_drained got %b want 0", issue_valid); end
    endtask

    task automatic test_wakeup_order();
        issue_ready = 1;
        disp(4'd1, 1, 4'd2, 32'd0, 0, 0, 32'h22); step();
        disp(4'd2, 0, 0, 32'h33, 0, 0, 32'h44);   step();
        idle(); cdb(1, 4'd2, 32'h10);             step();
        idle();
        n_checks++; if (issue_valid !== 1'b1 || issue_rob !== 4'd2) begin n_fail++; $display("FAIL wake_first got valid=%b rob=%0d want 1/2", issue_valid, issue_rob); end
        step();
        n_checks++; if (issue_valid !== 1'b1 || issue_rob !== 4'd1) begin n_fail++; $display("FAIL wake_second got valid=%b rob=%0d want 1/1", issue_valid, issue_rob); end
        n_checks++; if (issue_vj !== 32'h10 || issue_vk !== 32'h22) begin n_fail++; $display("FAIL wake_value got %h/%h want 10/22", issue_vj, issue_vk); end
        step();
        n_checks++; if (issue_valid !== 1'b0 || occupancy !== 0) begin n_fail++; $display("FAIL wake_drained got valid=%b occ=%0d want 0/0", issue_valid, occupancy); end
    endtask

    task automatic test_bypass();
        issue_ready = 1;
        disp(4'd5, 0, 0, 32'd1, 1, 4'd6, 32'd0);
        cdb(0, 4'd6, 32'hAA); cdb(1, 4'd6, 32'hBB);
        step(); idle(); step();
        n_checks++; if (issue_valid !== 1'b1 || issue_rob !== 4'd5) begin n_fail++; $display("FAIL bypass_issue got valid=%b rob=%0d want 1/5", issue_valid, issue_rob); end
        n_checks++; if (issue_vk !== 32'hAA) begin n_fail++; $display("FAIL bypass_port0_wins got %h want aa", issue_vk); end
        step();
    endtask

    task automatic test_full_and_order();
        issue_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            disp(TAG_W'(i), 1, 4'd7, 32'd0, 0, 0, 32'(i));
            step();
        end
        idle();
        n_checks++; if (occupancy !== DEPTH || disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_state got occ=%0d ready=%b want 16/0", occupancy, disp_ready); end
        disp(4'd0, 0, 0, 32'hDEAD, 0, 0, 32'hBEEF); step(); idle();
        n_checks++; if (occupancy !== DEPTH || issue_valid !== 1'b0) begin n_fail++; $display("FAIL full_drop got occ=%0d valid=%b want 16/0", occupancy, issue_valid); end
        cdb(0, 4'd7, 32'h77); issue_ready = 1; step(); idle();
        for (int i = 0; i < DEPTH; i++) begin
            step();
            n_checks++;
            if (issue_valid !== 1'b1 || issue_rob !== TAG_W'(i) || issue_vj !== 32'h77 || issue_vk !== 32'(i)) begin
                n_fail++; $display("FAIL full_order_%0d got valid=%b rob=%0d vj=%h vk=%h want 1/%0d/77/%h", i, issue_valid, issue_rob, issue_vj, issue_vk, i, i);
            end
        end
        n_checks++; if (occupancy !== 0) begin n_fail++; $display("FAIL full_empty got %0d want 0", occupancy); end
        step();
    endtask

    task automatic test_stall_flush();
        issue_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            disp(TAG_W'(i), 0, 0, 32'(i), 0, 0, 32'd0); step();
        end
        idle();
        n_checks++; if (occupancy !== 3 || issue_valid !== 1'b1 || issue_rob !== 4'd1) begin n_fail++; $display("FAIL stall_state got occ=%0d valid=%b rob=%0d want 3/1/1", occupancy, issue_valid, issue_rob); end
        step();
        n_checks++; if (issue_rob !== 4'd1 || issue_vj !== 32'd1 || occupancy !== 3) begin n_fail++; $display("FAIL stall_hold got rob=%0d vj=%0d occ=%0d want 1/1/3", issue_rob, issue_vj, occupancy); end
        flush = 1; cdb(0, 4'd9, 32'h99); disp(4'd8, 0, 0, 32'd8, 0, 0, 32'd0);
        step(); idle();
        n_checks++; if (issue_valid !== 1'b0 || occupancy !== 0) begin n_fail++; $display("FAIL flush_clear got valid=%b occ=%0d want 0/0", issue_valid, occupancy); end
        issue_ready = 1;
        disp(4'd9, 1, 4'd9, 32'd0, 0, 0, 32'd0); step(); idle(); step(); step();
        n_checks++; if (issue_valid !== 1'b0 || occupancy !== 1) begin n_fail++; $display("FAIL flush_cdb_dropped got valid=%b occ=%0d want 0/1", issue_valid, occupancy); end
        rdy = 0; cdb(1, 4'd9, 32'h5A); #1;
        n_checks++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL rdy_low_disp_ready got %b want 0", disp_ready); end
        step(); rdy = 1; idle(); step(); step();
        n_checks++; if (issue_valid !== 1'b0 || occupancy !== 1) begin n_fail++; $display("FAIL rdy_low_cdb_lost got valid=%b occ=%0d want 0/1", issue_valid, occupancy); end
        cdb(1, 4'd9, 32'h5A); step(); idle(); step();
        n_checks++; if (issue_valid !== 1'b1 || issue_vj !== 32'h5A) begin n_fail++; $display("FAIL rdy_high_wake got valid=%b vj=%h want 1/5a", issue_valid, issue_vj); end
        drain();
    endtask

    task automatic test_async_reset();
        issue_ready = 0;
        disp(4'd4, 0, 0, 32'h44, 0, 0, 32'd0); step();
        disp(4'd6, 0, 0, 32'h66, 0, 0, 32'd0); step(); idle();
        n_checks++; if (issue_valid !== 1'b1 || occupancy !== 1) begin n_fail++; $display("FAIL areset_pre got valid=%b occ=%0d want 1/1", issue_valid, occupancy); end
        #2 rst_n = 0; #1;
        n_checks++; if (issue_valid !== 1'b0 || occupancy !== 0 || issue_vj !== '0 || issue_rob !== '0) begin n_fail++; $display("FAIL areset_clear got valid=%b occ=%0d vj=%h rob=%0d want 0/0/0/0", issue_valid, occupancy, issue_vj, issue_rob); end
        @(negedge clk); rst_n = 1; step();
    endtask

    initial begin
        test_reset();
        test_ready_dispatch();
        test_wakeup_order();
        test_bypass();
        test_full_and_order();
        test_stall_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
